// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes and debounce state encodings shared by the farm-road sensor interface
package traffic_pkg;
  localparam int LIGHT_W = 2;
  localparam logic [LIGHT_W-1:0] LIGHT_RED = 2'b00;
  localparam logic [LIGHT_W-1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [LIGHT_W-1:0] LIGHT_GREEN = 2'b10;
  localparam logic [LIGHT_W-1:0] LIGHT_ILLEGAL = 2'b11;
  typedef enum logic [1:0] {LOW_STABLE, CHK_HIGH, HIGH_STABLE, CHK_LOW} db_state_t;
endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: two-flop synchronizer plus stability FSM, emits a registered one-cycle rise pulse
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  db_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic rise_nx, s, done;
  assign s = sync[1];
  assign done = cnt == CW'(DEBOUNCE_CYCLES - 1);
  assign level = state == HIGH_STABLE || state == CHK_LOW;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      state <= LOW_STABLE;
      cnt <= '0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      state <= state_nx;
      cnt <= cnt_nx;
      rise <= rise_nx;
    end
  end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    rise_nx = 1'b0;
    case (state)
      LOW_STABLE: if (s) begin state_nx = CHK_HIGH; cnt_nx = CW'(1); end
      CHK_HIGH:
        if (!s) state_nx = LOW_STABLE;
        else if (done) begin state_nx = HIGH_STABLE; rise_nx = 1'b1; end
        else cnt_nx = cnt + 1'b1;
      HIGH_STABLE: if (!s) begin state_nx = CHK_LOW; cnt_nx = CW'(1); end
      CHK_LOW:
        if (s) state_nx = HIGH_STABLE;
        else if (done) state_nx = LOW_STABLE;
        else cnt_nx = cnt + 1'b1;
      default: state_nx = LOW_STABLE;
    endcase
  end
endmodule

// File: rtl/farm_sensor_if.sv
// farm_sensor_if: farm-road vehicle queue, sFarm request, starvation and light-conflict monitor
module farm_sensor_if
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int QUEUE_W = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic loop_raw,
  input  logic exit_pulse,
  input  logic [LIGHT_W-1:0] H,
  input  logic [LIGHT_W-1:0] F,
  output logic sFarm,
  output logic [QUEUE_W-1:0] queue_cnt,
  output logic conflict,
  output logic starve
);
  logic arrive, depart, f_go, bad;
  logic [2:0] exit_sync;
  logic [QUEUE_W-1:0] queue_nx;
  logic [7:0] wait_cnt, wait_nx;
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_loop (
    .clk(clk),
    .rst(rst),
    .raw(loop_raw),
    .level(),
    .rise(arrive)
  );
  assign f_go = F == LIGHT_GREEN || F == LIGHT_YELLOW;
  assign depart = exit_sync[1] & ~exit_sync[2] & f_go;
  assign bad = (H != LIGHT_RED && F != LIGHT_RED) || H == LIGHT_ILLEGAL || F == LIGHT_ILLEGAL;
  always_comb begin
    queue_nx = (arrive && !depart && queue_cnt != '1) ? queue_cnt + 1'b1 :
               (depart && !arrive && queue_cnt != '0) ? queue_cnt - 1'b1 : queue_cnt;
    wait_nx = (queue_cnt != '0 && F == LIGHT_RED) ?
              (wait_cnt == 8'(MAX_WAIT) ? wait_cnt : wait_cnt + 1'b1) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      exit_sync <= '0;
      queue_cnt <= '0;
      sFarm <= 1'b0;
      wait_cnt <= '0;
      starve <= 1'b0;
      conflict <= 1'b0;
    end else begin
      exit_sync <= {exit_sync[1:0], exit_pulse};
      queue_cnt <= queue_nx;
      sFarm <= queue_nx != '0;
      wait_cnt <= wait_nx;
      starve <= wait_nx == 8'(MAX_WAIT);
      conflict <= conflict | bad;
    end
  end
endmodule

// File: tb/tb_farm_sensor_if.sv
// tb_farm_sensor_if: directed table-driven and sequence checks of the farm-road sensor interface
module tb_farm_sensor_if;
  logic clk = 1'b0, rst = 1'b1, loop_raw = 1'b0, exit_pulse = 1'b0;
  logic [1:0] h = 2'b00, f = 2'b00;
  logic sfarm, conflict, starve;
  logic [3:0] queue_cnt;
  int n_checks = 0, n_fail = 0;
  typedef struct {
    logic is_exit;
    logic [1:0] f;
    logic [3:0] q;
    logic s;
  } vec_t;
  vec_t tbl[8];
  farm_sensor_if dut (
    .clk(clk),
    .rst(rst),
    .loop_raw(loop_raw),
    .exit_pulse(exit_pulse),
    .H(h),
    .F(f),
    .sFarm(sfarm),
    .queue_cnt(queue_cnt),
    .conflict(conflict),
    .starve(starve)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    loop_raw = 1'b0;
    exit_pulse = 1'b0;
    h = 2'b00;
    step(2);
    rst = 1'b0;
  endtask
  task automatic arrive_one();
    loop_raw = 1'b1;
    step(8);
    loop_raw = 1'b0;
    step(8);
  endtask
  task automatic exit_one();
    exit_pulse = 1'b1;
    step(2);
    exit_pulse = 1'b0;
    step(4);
  endtask
  initial begin
    tbl[0] = '{1'b0, 2'b00, 4'd1, 1'b1};
    tbl[1] = '{1'b0, 2'b00, 4'd2, 1'b1};
    tbl[2] = '{1'b1, 2'b00, 4'd2, 1'b1};
    tbl[3] = '{1'b0, 2'b00, 4'd3, 1'b1};
    tbl[4] = '{1'b1, 2'b10, 4'd2, 1'b1};
    tbl[5] = '{1'b1, 2'b01, 4'd1, 1'b1};
    tbl[6] = '{1'b1, 2'b10, 4'd0, 1'b0};
    tbl[7] = '{1'b1, 2'b10, 4'd0, 1'b0};
    // reset held with the loop occupied, then exact arrival latency
    rst = 1'b1;
    loop_raw = 1'b1;
    step(3);
    check("rst_sfarm", sfarm, 0);
    check("rst_queue", queue_cnt, 0);
    check("rst_conflict", conflict, 0);
    check("rst_starve", starve, 0);
    rst = 1'b0;
    step(6);
    check("lat_sfarm_early", sfarm, 0);
    step(1);
    check("lat_sfarm", sfarm, 1);
    check("lat_queue", queue_cnt, 1);
    // glitches of 2 and 3 cycles never count
    do_reset();
    f = 2'b00;
    loop_raw = 1'b1;
    step(2);
    loop_raw = 1'b0;
    step(10);
    check("glitch2_queue", queue_cnt, 0);
    check("glitch2_sfarm", sfarm, 0);
    loop_raw = 1'b1;
    step(3);
    loop_raw = 1'b0;
    step(10);
    check("glitch3_queue", queue_cnt, 0);
    // table: arrivals and exits under varied farm lights
    do_reset();
    for (int i = 0; i < 8; i++) begin
      f = tbl[i].f;
      if (tbl[i].is_exit) exit_one();
      else arrive_one();
      check($sformatf("tbl%0d_queue", i), queue_cnt, tbl[i].q);
      check($sformatf("tbl%0d_sfarm", i), sfarm, tbl[i].s);
    end
    // arrive and depart land on the same cycle
    do_reset();
    f = 2'b10;
    arrive_one();
    arrive_one();
    check("same_pre", queue_cnt, 2);
    loop_raw = 1'b1;
    step(4);
    exit_pulse = 1'b1;
    step(2);
    exit_pulse = 1'b0;
    step(1);
    check("same_cycle", queue_cnt, 2);
    loop_raw = 1'b0;
    step(8);
    check("same_after", queue_cnt, 2);
    // saturation at 15 and floor at 0
    do_reset();
    f = 2'b10;
    for (int i = 0; i < 17; i++) begin
      arrive_one();
      if (i == 14) check("sat_15", queue_cnt, 15);
    end
    check("sat_17", queue_cnt, 15);
    for (int i = 0; i < 17; i++) exit_one();
    check("floor_queue", queue_cnt, 0);
    check("floor_sfarm", sfarm, 0);
    // starvation boundary and sticky conflict
    do_reset();
    f = 2'b10;
    arrive_one();
    check("starve_init", starve, 0);
    f = 2'b00;
    step(14);
    check("starve_14", starve, 0);
    step(1);
    check("starve_15", starve, 1);
    step(3);
    check("starve_hold", starve, 1);
    f = 2'b10;
    step(1);
    check("starve_clear", starve, 0);
    check("no_conflict", conflict, 0);
    h = 2'b10;
    f = 2'b00;
    step(1);
    check("h_green_f_red", conflict, 0);
    f = 2'b01;
    step(1);
    h = 2'b00;
    f = 2'b10;
    check("conflict_set", conflict, 1);
    step(5);
    check("conflict_sticky", conflict, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("conflict_rst", conflict, 0);
    f = 2'b11;
    step(1);
    f = 2'b00;
    check("conflict_f_illegal", conflict, 1);
    do_reset();
    h = 2'b11;
    step(1);
    h = 2'b00;
    check("conflict_h_illegal", conflict, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
